// File: rtl/mmio_io_decoder.sv
// mmio_io_decoder: splits the core data port between external dmem and an I/O register bank.
// Optional MMIO_DEBOUNCE_EN inserts a per-button debouncer after the button synchronisers.
module mmio_io_decoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_BTN     = 2,
    parameter int unsigned SW_W      = 16,
    parameter int unsigned LED_W     = 12,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              dmemWe,
    input  logic [DATA_W-1:0] dmemReadData,
    input  logic [N_BTN-1:0]  btn,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       dispValue
);

    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_SW    = 3'd0;
    localparam logic [IDX_W-1:0] IDX_LEVEL = 3'd1;
    localparam logic [IDX_W-1:0] IDX_PRESS = 3'd2;
    localparam logic [IDX_W-1:0] IDX_LED   = 3'd3;
    localparam logic [IDX_W-1:0] IDX_DISP  = 3'd4;
    localparam logic [IDX_W-1:0] IDX_CYCLE = 3'd5;

    logic             io;
    logic [IDX_W-1:0] idx;
    logic             io_wr;
    logic             io_rd;

    assign io     = addr[ADDR_W-1];
    assign idx    = addr[4:2];
    assign io_wr  = write & io;
    assign io_rd  = read & io;
    assign dmemWe = write & ~io;

    // Byte-lane and upper index bits play no part in decode
    logic unused_addr;
    assign unused_addr = ^{addr[1:0], addr[ADDR_W-2:5]};

    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
        end
    end

    logic [N_BTN-1:0] btn_s1;
    logic [N_BTN-1:0] btn_s2;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : g_db
        db_state_e        state_q;
        db_state_e        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             differ;
        logic             done;
        logic             toggle;

        assign differ = btn_s2[g] ^ level_q;
        // Toggle on the edge that would bring the count to DB_CYCLES-1
        assign done   = (cnt_q == CNT_W'(DB_CYCLES - 2));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= DB_STABLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_q ^ toggle;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                DB_STABLE:  if (differ) state_d = DB_PENDING;
                DB_PENDING: if (!differ || done) state_d = DB_STABLE;
                default:    state_d = DB_STABLE;
            endcase
        end

        always_comb begin
            cnt_d  = '0;
            toggle = 1'b0;
            if (state_q == DB_PENDING && differ) begin
                toggle = done;
                cnt_d  = done ? '0 : cnt_q + CNT_W'(1);
            end
        end

        assign btn_level[g] = level_q;
        assign btn_rise[g]  = toggle & ~level_q;
    end
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;

    assign btn_level = btn_s2;
    assign btn_rise  = btn_s1 & ~btn_s2;
`endif

    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_clr;

    // Clear-on-read drops every flag; W1C drops the written ones; a new rise always wins
    always_comb begin
        press_clr = '0;
        if (io_rd && idx == IDX_PRESS) press_clr = '1;
        if (io_wr && idx == IDX_PRESS) press_clr = press_clr | writeData[N_BTN-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_q <= '0;
        end else begin
            press_q <= (press_q & ~press_clr) | btn_rise;
        end
    end

    logic [LED_W-1:0] led_q;
    logic [31:0]      disp_q;
    logic [31:0]      cycle_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            disp_q  <= '0;
            cycle_q <= '0;
        end else begin
            if (io_wr && idx == IDX_LED)  led_q  <= writeData[LED_W-1:0];
            if (io_wr && idx == IDX_DISP) disp_q <= 32'(writeData);
            if (io_wr && idx == IDX_CYCLE) cycle_q <= '0;
            else                           cycle_q <= cycle_q + 32'd1;
        end
    end

    assign led       = led_q;
    assign dispValue = disp_q;

    logic [DATA_W-1:0] io_rdata;

    always_comb begin
        io_rdata = '0;
        case (idx)
            IDX_SW:    io_rdata = DATA_W'(sw_s2);
            IDX_LEVEL: io_rdata = DATA_W'(btn_level);
            IDX_PRESS: io_rdata = DATA_W'(press_q);
            IDX_LED:   io_rdata = DATA_W'(led_q);
            IDX_DISP:  io_rdata = DATA_W'(disp_q);
            IDX_CYCLE: io_rdata = DATA_W'(cycle_q);
            default:   io_rdata = '0;
        endcase
    end

    assign readData = io ? io_rdata : dmemReadData;

endmodule

// File: tb/tb_mmio_io_decoder.sv
// Directed bench for mmio_io_decoder: bus vector table plus reset, counter, switch and button sequences.
module tb_mmio_io_decoder;

`ifdef MMIO_DEBOUNCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic        write;
    logic        read;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        dmemWe;
    logic [31:0] dmemReadData;
    logic [1:0]  btn;
    logic [15:0] switch;
    logic [11:0] led;
    logic [31:0] dispValue;

    int n_vec  = 0;
    int n_miss = 0;

    mmio_io_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .write        (write),
        .read         (read),
        .writeData    (writeData),
        .readData     (readData),
        .dmemWe       (dmemWe),
        .dmemReadData (dmemReadData),
        .btn          (btn),
        .switch       (switch),
        .led          (led),
        .dispValue    (dispValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] dmem;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic [11:0] exp_led;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, input string name, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, readData, exp);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        addr = a; writeData = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h8C, 1'b1, 1'b0, 32'h00000ABC, 32'h11111111, 32'h00000000, 1'b0, 12'hABC, 32'h00000000};
        vecs[1]  = '{8'h90, 1'b1, 1'b0, 32'h12345678, 32'h11111111, 32'h00000000, 1'b0, 12'hABC, 32'h12345678};
        vecs[2]  = '{8'h10, 1'b1, 1'b0, 32'h0000DEAD, 32'h00000000, 32'h00000000, 1'b1, 12'hABC, 32'h12345678};
        vecs[3]  = '{8'h10, 1'b0, 1'b1, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 12'hABC, 32'h12345678};
        vecs[4]  = '{8'h8C, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000ABC, 1'b0, 12'hABC, 32'h12345678};
        vecs[5]  = '{8'h8D, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000ABC, 1'b0, 12'hABC, 32'h12345678};
        vecs[6]  = '{8'h90, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 12'hABC, 32'h12345678};
        vecs[7]  = '{8'h98, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 12'hABC, 32'h12345678};
        vecs[8]  = '{8'h9C, 1'b0, 1'b1, 32'h00000000, 32'h55555555, 32'h00000000, 1'b0, 12'hABC, 32'h12345678};
        vecs[9]  = '{8'h0C, 1'b1, 1'b0, 32'h00000555, 32'h0BADBEEF, 32'h0BADBEEF, 1'b1, 12'hABC, 32'h12345678};
        vecs[10] = '{8'h8C, 1'b1, 1'b0, 32'hFFFFF123, 32'h00000000, 32'h00000ABC, 1'b0, 12'h123, 32'h12345678};
        vecs[11] = '{8'h90, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 12'h123, 32'h00000000};
        vecs[12] = '{8'h80, 1'b1, 1'b0, 32'h0000FFFF, 32'h00000000, 32'h00000000, 1'b0, 12'h123, 32'h00000000};
        vecs[13] = '{8'h84, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 12'h123, 32'h00000000};
        vecs[14] = '{8'h14, 1'b0, 1'b1, 32'h00000000, 32'h87654321, 32'h87654321, 1'b0, 12'h123, 32'h00000000};

        reset = 1'b0; addr = '0; write = 1'b0; read = 1'b0; writeData = '0;
        dmemReadData = '0; btn = '0; switch = '0;
        repeat (3) tick();
        reset = 1'b1;

        // Reset behaviour with LED/DISP loaded and CYCLE running
        bus_write(8'h8C, 32'h000005A5);
        check("led_5a5", 32'(led), 32'h5A5);
        bus_write(8'h90, 32'hFFFF0000);
        repeat (5) tick();
        peek(8'h94, "cycle_run", 32'd7);
        reset = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_disp", dispValue, 32'h0);
        check("rst_cycle", readData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("cycle_after_rst", readData, 32'h0);
        peek(8'h88, "press_after_rst", 32'h0);
        tick();
        peek(8'h94, "cycle_first_edge", 32'd1);

        // CYCLE write clears on its edge, then resumes counting
        writeData = 32'hDEADBEEF; write = 1'b1;
        #1;
        check("cycle_pre_clr", readData, 32'd1);
        tick();
        write = 1'b0;
        #1;
        check("cycle_clr", readData, 32'd0);
        tick();
        check("cycle_resume1", readData, 32'd1);
        tick();
        check("cycle_resume2", readData, 32'd2);

        for (int i = 0; i < 15; i++) begin
            addr = vecs[i].addr; write = vecs[i].wr; read = vecs[i].rd;
            writeData = vecs[i].wdata; dmemReadData = vecs[i].dmem;
            #1;
            check($sformatf("v%0d_rdata", i), readData, vecs[i].exp_rd);
            check($sformatf("v%0d_dmemwe", i), 32'(dmemWe), 32'(vecs[i].exp_we));
            tick();
            check($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
            check($sformatf("v%0d_disp", i), dispValue, vecs[i].exp_disp);
        end
        write = 1'b0; read = 1'b0; dmemReadData = '0;

        // Switch sampling: two-edge latency
        switch = 16'h00F0;
        addr = 8'h80;
        tick();
        check("sw_edge1", readData, 32'h0);
        tick();
        check("sw_edge2", readData, 32'h000000F0);

        // Button 0 press: level and PRESS rise together after LAT edges
        btn[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            peek(8'h84, $sformatf("btn_level_e%0d", k), (k >= LAT) ? 32'h1 : 32'h0);
            peek(8'h88, $sformatf("btn_press_e%0d", k), (k >= LAT) ? 32'h1 : 32'h0);
        end
        addr = 8'h88; read = 1'b1;
        #1;
        check("press_read", readData, 32'h1);
        tick();
        read = 1'b0;
        #1;
        check("press_clr_on_read", readData, 32'h0);
        peek(8'h84, "level_held", 32'h1);

        // Release never sets PRESS
        btn[0] = 1'b0;
        repeat (LAT + 2) tick();
        peek(8'h84, "level_released", 32'h0);
        peek(8'h88, "press_no_fall", 32'h0);

`ifdef MMIO_DEBOUNCE_EN
        // 10-cycle glitch on btn[0] is rejected
        btn[0] = 1'b1;
        repeat (10) tick();
        btn[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            peek(8'h84, $sformatf("glitch_level_%0d", k), 32'h0);
        end
        peek(8'h88, "glitch_press", 32'h0);
`else
        // 3-cycle btn[1] pulse sets PRESS[1] at the second edge
        btn[1] = 1'b1;
        tick();
        peek(8'h88, "pulse_press_e1", 32'h0);
        tick();
        peek(8'h88, "pulse_press_e2", 32'h2);
        tick();
        btn[1] = 1'b0;
        repeat (4) tick();
        peek(8'h84, "pulse_level_low", 32'h0);
        peek(8'h88, "pulse_press_sticky", 32'h2);
        bus_write(8'h88, 32'h2);
        #1;
        check("pulse_w1c", readData, 32'h0);
`endif

        // New press edge coincides with a W1C of bit 0: set wins
        btn[0] = 1'b1;
        repeat (LAT - 1) tick();
        addr = 8'h88; writeData = 32'h1; write = 1'b1;
        #1;
        check("collide_pre", readData, 32'h0);
        tick();
        write = 1'b0;
        #1;
        check("collide_set_wins", readData, 32'h1);
        bus_write(8'h88, 32'h1);
        #1;
        check("w1c_clear", readData, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
